spi_tx_master: RTL and testbench



---
 rtl/spi_tx_master.sv | 272 +++++++++++++++++++++++++++
 tb/tb_spi_tx_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_master.sv
// -----------------------------------------------------------------------------
// spi_tx_master
//
// Transmit-only SPI master, mode 1 (CPOL=0, CPHA=1), MSB first.
// Bytes are written into a small TX FIFO and shifted out in frames: chip
// select stays low across back-to-back bytes while the FIFO keeps supplying
// data, then is held high for at least CS_GAP_CLKS clocks between frames.
//
// Parameters
//   CLKS_PER_HALF_BIT  clk cycles per SCK half-period (>= 1)
//   FIFO_DEPTH         TX FIFO entries (power of two, >= 2)
//   CS_GAP_CLKS        minimum clk cycles CS stays high between frames (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   tx_data    byte to send
//   tx_valid   write request for tx_data
//   tx_ready   FIFO not full (from the registered count)
//   busy       FSM not idle or FIFO non-empty
//   done       1-clk pulse per byte fully shifted
//   sck        SPI clock, idles low
//   cs         active-low chip select
//   mosi       serial data out
//   state_dbg  current FSM state encoding, for observation only
//
// Handshake: a byte is accepted on a rising clk edge where tx_valid=1 and
// tx_ready=1. tx_valid while tx_ready=0 is ignored (the byte is dropped);
// tx_ready never depends on tx_valid or on a same-cycle pop.
// -----------------------------------------------------------------------------
module spi_tx_master #(
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int FIFO_DEPTH        = 4,
   parameter int CS_GAP_CLKS       = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       sck,
   output logic       cs,
   output logic       mosi,
   output logic [2:0] state_dbg
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
   localparam int GW = (CS_GAP_CLKS > 1) ? $clog2(CS_GAP_CLKS) : 1;

   localparam logic [HW-1:0] HALF_LAST  = HW'(CLKS_PER_HALF_BIT - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(CS_GAP_CLKS - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CS_SETUP = 3'd1,
      S_SHIFT    = 3'd2,
      S_CS_HOLD  = 3'd3,
      S_GAP      = 3'd4
   } state_t;

   // ---------------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          nonempty_q, nonempty_d;
   logic          push;
   logic          pop;
   logic          fifo_avail;
   logic [7:0]    fifo_head;

   assign tx_ready  = (count_q != COUNT_FULL);
   assign push      = tx_valid && tx_ready;
   assign fifo_head = mem_q[rd_ptr_q];

   // The FSM looks at a registered copy of "count non-empty", so a byte
   // written into an empty FIFO is taken one edge later than the count
   // shows it. This gives a fixed two-edge push-to-CS latency and keeps the
   // FIFO free of any write-to-read bypass path. The count term guards
   // against the lagging flag ever allowing a pop from an empty FIFO.
   assign fifo_avail = nonempty_q && (count_q != '0);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      nonempty_d = (count_q != '0);
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         nonempty_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         nonempty_q <= nonempty_d;
      end
   end

   // Storage needs no reset: entries are only read behind a valid count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Frame / shift FSM
   // ---------------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [HW-1:0] half_cnt_q, half_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          sck_q, sck_d;
   logic          cs_q, cs_d;
   logic          mosi_q, mosi_d;
   logic          done_q, done_d;
   logic          half_last;

   assign half_last = (half_cnt_q == HALF_LAST);

   always_comb begin
      state_d    = state_q;
      half_cnt_d = half_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      shreg_d    = shreg_q;
      sck_d      = sck_q;
      cs_d       = cs_q;
      mosi_d     = mosi_q;
      done_d     = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fifo_avail) begin
               pop        = 1'b1;
               shreg_d    = fifo_head;
               mosi_d     = fifo_head[7];
               cs_d       = 1'b0;
               bit_cnt_d  = '0;
               half_cnt_d = '0;
               state_d    = S_CS_SETUP;
            end
         end

         S_CS_SETUP: begin
            if (half_last) begin
               // First rising edge: bit 7 is already on mosi from the load.
               half_cnt_d = '0;
               sck_d      = 1'b1;
               mosi_d     = shreg_q[7];
               state_d    = S_SHIFT;
            end else begin
               half_cnt_d = half_cnt_q + 1'b1;
            end
         end

         S_SHIFT: begin
            if (!half_last) begin
               half_cnt_d = half_cnt_q + 1'b1;
            end else begin
               half_cnt_d = '0;
               if (!sck_q) begin
                  // End of low phase: rising edge, launch the current bit.
                  sck_d  = 1'b1;
                  mosi_d = shreg_q[3'd7 - bit_cnt_q];
               end else begin
                  // End of high phase: falling edge, receiver samples here.
                  sck_d = 1'b0;
                  if (bit_cnt_q == 3'd7) begin
                     done_d = 1'b1;
                     if (fifo_avail) begin
                        // Next byte continues the frame; mosi keeps bit 0
                        // until the following rising edge launches bit 7.
                        pop       = 1'b1;
                        shreg_d   = fifo_head;
                        bit_cnt_d = '0;
                     end else begin
                        // The hold phase stands in for the last low phase.
                        state_d = S_CS_HOLD;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
         end

         S_CS_HOLD: begin
            if (half_last) begin
               half_cnt_d = '0;
               cs_d       = 1'b1;
               mosi_d     = 1'b0;
               gap_cnt_d  = '0;
               state_d    = S_GAP;
            end else begin
               half_cnt_d = half_cnt_q + 1'b1;
            end
         end

         S_GAP: begin
            // Runs to completion even when the FIFO already holds data.
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         half_cnt_q <= '0;
         bit_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         shreg_q    <= '0;
         sck_q      <= 1'b0;
         cs_q       <= 1'b1;
         mosi_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         half_cnt_q <= half_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         shreg_q    <= shreg_d;
         sck_q      <= sck_d;
         cs_q       <= cs_d;
         mosi_q     <= mosi_d;
         done_q     <= done_d;
      end
   end

   assign sck       = sck_q;
   assign cs        = cs_q;
   assign mosi      = mosi_q;
   assign done      = done_q;
   assign busy      = (state_q != S_IDLE) || (count_q != '0);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// -----------------------------------------------------------------------------
// tb_spi_tx_master
//
// Directed bench for spi_tx_master with default parameters (2 clks per SCK
// half-bit, 4-entry FIFO, 10-clk CS gap). A negedge monitor acts as the SPI
// slave (samples mosi on sck falling edges while cs is low) and records frame
// timing and protocol violations; sequences compare those against values
// worked out by hand.
// -----------------------------------------------------------------------------
module tb_spi_tx_master;

   localparam int HALF = 2;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       sck;
   logic       cs;
   logic       mosi;
   logic [2:0] state_dbg;

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   spi_tx_master #(
      .CLKS_PER_HALF_BIT (2),
      .FIFO_DEPTH        (4),
      .CS_GAP_CLKS       (10)
   ) dut (
      .clk       (clk),
      .reset     (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .done      (done),
      .sck       (sck),
      .cs        (cs),
      .mosi      (mosi),
      .state_dbg (state_dbg)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [7:0] exp_q [$];
   logic [7:0] rx_q  [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_rx(input string name);
      logic [7:0] e;
      logic [7:0] a;
      check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         check({name, "_byte"}, {24'h0, a}, {24'h0, e});
      end
      exp_q.delete();
      rx_q.delete();
   endtask

   // ---------------------------------------------------------------------------
   // Monitor / SPI slave model
   // ---------------------------------------------------------------------------
   logic prev_sck  = 1'b0;
   logic prev_cs   = 1'b1;
   logic prev_mosi = 1'b0;
   logic prev_done = 1'b0;
   logic [7:0] shift_m = '0;
   int bit_cnt_m     = 0;
   int hi_run        = 0;
   int lo_run        = 0;
   int fall_cnt      = 0;
   int done_cnt      = 0;
   int frame_cnt     = 0;
   int width_err     = 0;
   int mosi_err      = 0;
   int sck_err       = 0;
   int done_err      = 0;
   int cs_fall_edge  = 0;
   int cs_rise_edge  = -1000;
   int last_fall_edge = 0;
   int gap_len       = 0;

   always @(negedge clk) begin
      logic sck_rise, sck_fall, cs_fall, cs_rise;
      if (rst) begin
         bit_cnt_m = 0;
         hi_run    = 0;
         lo_run    = 0;
      end else begin
         sck_rise = sck && !prev_sck;
         sck_fall = !sck && prev_sck;
         cs_fall  = !cs && prev_cs;
         cs_rise  = cs && !prev_cs;
         if (cs && sck) sck_err++;
         if (sck_rise) begin
            if (lo_run != HALF) width_err++;
            lo_run = 0;
            hi_run = 1;
         end else if (sck) begin
            hi_run++;
         end
         if (sck_fall) begin
            if (hi_run != HALF) width_err++;
            hi_run = 0;
            lo_run = 1;
            fall_cnt++;
            last_fall_edge = edge_cnt;
            if (!cs) begin
               shift_m = {shift_m[6:0], prev_mosi};
               bit_cnt_m++;
               if (bit_cnt_m == 8) begin
                  rx_q.push_back(shift_m);
                  bit_cnt_m = 0;
               end
            end
         end else if (!sck && !cs && !cs_fall) begin
            lo_run++;
         end
         if (cs_fall) begin
            cs_fall_edge = edge_cnt;
            gap_len      = edge_cnt - cs_rise_edge;
            lo_run       = 1;
            bit_cnt_m    = 0;
            frame_cnt++;
         end
         if (cs_rise) begin
            if (lo_run != HALF) width_err++;
            cs_rise_edge = edge_cnt;
            lo_run       = 0;
            bit_cnt_m    = 0;
         end
         if ((mosi !== prev_mosi) && !sck_rise && !cs_fall && !cs_rise) mosi_err++;
         if (done) begin
            done_cnt++;
            if (prev_done) done_err++;
         end
      end
      prev_sck  = sck;
      prev_cs   = cs;
      prev_mosi = mosi;
      prev_done = done;
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (called at a negedge, return at a negedge)
   // ---------------------------------------------------------------------------
   task automatic push_byte(input logic [7:0] b, output int push_edge);
      tx_valid  = 1'b1;
      tx_data   = b;
      push_edge = edge_cnt + 1;
      @(negedge clk);
      tx_valid  = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int i = 0; i < budget && busy; i++) @(negedge clk);
      check({name, "_idle"}, {31'h0, busy}, 32'h0);
   endtask

   task automatic wait_cs_level(input string name, input logic lvl, input int budget);
      for (int i = 0; i < budget && (cs !== lvl); i++) @(negedge clk);
      check({name, "_cs_wait"}, {31'h0, cs}, {31'h0, lvl});
   endtask

   // ---------------------------------------------------------------------------
   // Vectors: single-byte frames
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_serial;   // bits as seen on mosi, first sampled in bit 7
      int         exp_latency;  // push edge -> cs fall edge
      int         exp_pulses;   // sck falling edges
      int         exp_cs_low;   // edges from cs fall to cs rise
      int         exp_tail;     // edges from last sck fall to cs rise
   } vec_t;

   vec_t vecs [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pe;
      int f0, d0, fr0;
      int nf;
      logic ps;

      vecs[0] = '{data: 8'hA5, exp_serial: 8'b1010_0101, exp_latency: 2, exp_pulses: 8, exp_cs_low: 34, exp_tail: 2};
      vecs[1] = '{data: 8'h3C, exp_serial: 8'b0011_1100, exp_latency: 2, exp_pulses: 8, exp_cs_low: 34, exp_tail: 2};
      vecs[2] = '{data: 8'h81, exp_serial: 8'b1000_0001, exp_latency: 2, exp_pulses: 8, exp_cs_low: 34, exp_tail: 2};
      vecs[3] = '{data: 8'h7E, exp_serial: 8'b0111_1110, exp_latency: 2, exp_pulses: 8, exp_cs_low: 34, exp_tail: 2};

      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      // Reset held for 10 clocks: {cs,sck,mosi,tx_ready,busy,done}
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("reset_hold", {26'h0, cs, sck, mosi, tx_ready, busy, done}, 32'b100100);
      end
      rst = 1'b0;
      @(negedge clk);

      // Table-driven single-byte frames
      for (int v = 0; v < 4; v++) begin
         f0  = fall_cnt;
         d0  = done_cnt;
         fr0 = frame_cnt;
         push_byte(vecs[v].data, pe);
         exp_q.push_back(vecs[v].exp_serial);
         wait_idle("vec", 300);
         check("vec_latency", 32'(cs_fall_edge - pe), 32'(vecs[v].exp_latency));
         check("vec_pulses",  32'(fall_cnt - f0), 32'(vecs[v].exp_pulses));
         check("vec_done",    32'(done_cnt - d0), 32'd1);
         check("vec_frames",  32'(frame_cnt - fr0), 32'd1);
         check("vec_cs_low",  32'(cs_rise_edge - cs_fall_edge), 32'(vecs[v].exp_cs_low));
         check("vec_tail",    32'(cs_rise_edge - last_fall_edge), 32'(vecs[v].exp_tail));
         check_rx("vec_rx");
         @(negedge clk);
      end

      // Fill the FIFO during a CS gap, then overflow it
      f0  = fall_cnt;
      d0  = done_cnt;
      fr0 = frame_cnt;
      push_byte(8'h11, pe);
      exp_q.push_back(8'h11);
      wait_cs_level("fill_start", 1'b0, 50);
      wait_cs_level("fill_gap", 1'b1, 100);
      push_byte(8'h00, pe);
      push_byte(8'h01, pe);
      push_byte(8'h80, pe);
      push_byte(8'hFF, pe);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'hFF);
      check("full_ready", {31'h0, tx_ready}, 32'h0);
      check("full_busy", {31'h0, busy}, 32'h1);
      push_byte(8'h55, pe);
      check("full_ready_after_drop", {31'h0, tx_ready}, 32'h0);
      check("full_cs_in_gap", {31'h0, cs}, 32'h1);
      wait_idle("full", 600);
      check("full_pulses", 32'(fall_cnt - f0), 32'd40);
      check("full_done",   32'(done_cnt - d0), 32'd5);
      check("full_frames", 32'(frame_cnt - fr0), 32'd2);
      check("full_cs_low", 32'(cs_rise_edge - cs_fall_edge), 32'd130);
      check_rx("full_rx");
      @(negedge clk);

      // Reset after the 3rd sck falling edge of a frame
      d0 = done_cnt;
      push_byte(8'h3C, pe);
      push_byte(8'h5A, pe);
      push_byte(8'h99, pe);
      nf = 0;
      ps = sck;
      for (int i = 0; i < 200 && nf < 3; i++) begin
         @(negedge clk);
         if (ps && !sck) nf++;
         ps = sck;
      end
      check("abort_reach_fall3", 32'(nf), 32'd3);
      #2 rst = 1'b1;
      #1;
      check("abort_cs_sck", {30'h0, cs, sck}, 32'b10);
      check("abort_busy_done", {30'h0, busy, done}, 32'b00);
      check("abort_ready", {31'h0, tx_ready}, 32'h1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_idle", {30'h0, busy, cs}, 32'b01);
      check("abort_rx_empty", 32'(rx_q.size()), 32'd0);
      rx_q.delete();

      // First byte after reset: fresh setup phase, normal latency
      push_byte(8'hC3, pe);
      exp_q.push_back(8'hC3);
      wait_idle("post_reset", 300);
      check("post_reset_latency", 32'(cs_fall_edge - pe), 32'd2);
      check("post_reset_cs_low", 32'(cs_rise_edge - cs_fall_edge), 32'd34);
      check_rx("post_reset_rx");
      @(negedge clk);

      // Byte pushed during the CS gap waits out the whole gap
      fr0 = frame_cnt;
      push_byte(8'h55, pe);
      exp_q.push_back(8'h55);
      wait_cs_level("gap_start", 1'b0, 50);
      wait_cs_level("gap_enter", 1'b1, 100);
      push_byte(8'hAA, pe);
      exp_q.push_back(8'hAA);
      check("gap_cs_still_high", {31'h0, cs}, 32'h1);
      wait_idle("gap", 400);
      check("gap_min_high", {31'h0, (gap_len >= 10)}, 32'h1);
      check("gap_frames", 32'(frame_cnt - fr0), 32'd2);
      check_rx("gap_rx");

      // Protocol checks accumulated over the whole run
      check("sck_width_errors", 32'(width_err), 32'd0);
      check("mosi_change_errors", 32'(mosi_err), 32'd0);
      check("sck_while_cs_high", 32'(sck_err), 32'd0);
      check("done_width_errors", 32'(done_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
